sram_sp_bw: RTL and testbench

Parametrised single-port synchronous SRAM model with byte-lane write masking, an optional output register stage and a built-in post-reset initialisation sweep. It replaces the fixed 32x256 SRAM model as the on-chip buffer in simulation and pre-synthesis flows, keeping the active-low CEN/WEN request style. Unlike the fixed model, it also adds a read-valid flag, holds read data instead of driving X, and provides a BUSY indication while memory is being initialised.

---
 rtl/sram_sp_bw.sv | 217 +++++++++++++++++++++
 tb/tb_sram_sp_bw.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_bw.sv
// sram_sp_bw
// Single-port synchronous SRAM model with active-low chip/write enables,
// per-byte write masking, an optional output register stage and a sweep
// that fills every word with INIT_VAL after reset. Read data is held
// between reads and qualified by a one-cycle QV pulse.
module sram_sp_bw #(
  parameter int unsigned    BPW      = 32,
  parameter int unsigned    WORD     = 256,
  parameter int unsigned    ADDR     = $clog2(WORD),
  parameter int unsigned    OREG     = 0,
  parameter logic [BPW-1:0] INIT_VAL = {BPW{1'b0}}
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CEN,
  input  logic               WEN,
  input  logic [BPW/8-1:0]   BWEN,
  input  logic [ADDR-1:0]    A,
  input  logic [BPW-1:0]     D,
  output logic [BPW-1:0]     Q,
  output logic               QV,
  output logic               BUSY
);

  localparam int unsigned NB = BPW / 8;

  // Address compare is done one bit wider so WORD itself is representable
  // even when WORD is an exact power of two.
  localparam logic [ADDR:0]   WORD_EXT = (ADDR + 1)'(WORD);
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(WORD - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  // Merge new data into an existing word, one byte lane per set mask bit.
  function automatic logic [BPW-1:0] merge_bytes(
    input logic [BPW-1:0] old_word,
    input logic [BPW-1:0] new_word,
    input logic [NB-1:0]  lane_en
  );
    logic [BPW-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lane_en[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [BPW-1:0]  mem [0:WORD-1];

  state_t          state_r;
  state_t          state_s;
  logic [ADDR-1:0] cnt_r;
  logic [ADDR-1:0] cnt_s;
  logic            busy_r;

  logic            addr_ok_s;
  logic            req_ok_s;
  logic            wr_req_s;
  logic            rd_req_s;
  logic [BPW-1:0]  rd_data_s;

  logic            mem_we_s;
  logic [ADDR-1:0] mem_wa_s;
  logic [BPW-1:0]  mem_wd_s;
  logic [NB-1:0]   mem_bm_s;

  // Next-state and sweep-counter logic; reset always restarts the sweep.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (RST) begin
      state_s = S_INIT;
      cnt_s   = {ADDR{1'b0}};
    end else begin
      case (state_r)
        S_INIT: begin
          if (cnt_r == LAST_ADDR) begin
            state_s = S_IDLE;
            cnt_s   = {ADDR{1'b0}};
          end else begin
            state_s = S_INIT;
            cnt_s   = cnt_r + ADDR'(1'b1);
          end
        end
        S_IDLE: begin
          state_s = S_IDLE;
          cnt_s   = {ADDR{1'b0}};
        end
        default: begin
          state_s = S_INIT;
          cnt_s   = {ADDR{1'b0}};
        end
      endcase
    end
  end

  // State, sweep counter and BUSY flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_INIT;
      cnt_r   <= {ADDR{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == S_INIT);
    end
  end

  // Request decode: only honoured in IDLE and never on a reset edge.
  always_comb begin
    addr_ok_s = ({1'b0, A} < WORD_EXT);
    req_ok_s  = (!RST) && (state_r == S_IDLE) && (!CEN);
    wr_req_s  = req_ok_s && (!WEN) && addr_ok_s;
    rd_req_s  = req_ok_s && WEN;
    if (addr_ok_s) begin
      rd_data_s = mem[A];
    end else begin
      rd_data_s = {BPW{1'bx}};
    end
  end

  // Single write port shared by the init sweep and user writes.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = {ADDR{1'b0}};
    mem_wd_s = {BPW{1'b0}};
    mem_bm_s = {NB{1'b0}};
    if ((!RST) && (state_r == S_INIT)) begin
      mem_we_s = 1'b1;
      mem_wa_s = cnt_r;
      mem_wd_s = INIT_VAL;
      mem_bm_s = {NB{1'b1}};
    end else if (wr_req_s) begin
      mem_we_s = 1'b1;
      mem_wa_s = A;
      mem_wd_s = D;
      mem_bm_s = ~BWEN;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Storage array; contents survive reset until the sweep overwrites them.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem[mem_wa_s] <= merge_bytes(mem[mem_wa_s], mem_wd_s, mem_bm_s);
    end
  end

  logic [BPW-1:0] q_r;
  logic           qv_r;

  generate
    if (OREG != 0) begin : g_oreg
      logic [BPW-1:0] pipe_d_r;
      logic           pipe_v_r;

      // First read stage: capture the array word and its valid bit.
      always_ff @(posedge CLK) begin
        if (RST) begin
          pipe_d_r <= {BPW{1'b0}};
          pipe_v_r <= 1'b0;
        end else begin
          if (rd_req_s) begin
            pipe_d_r <= rd_data_s;
          end else begin
            pipe_d_r <= pipe_d_r;
          end
          pipe_v_r <= rd_req_s;
        end
      end

      // Output stage: Q updates only when a read completes, otherwise holds.
      always_ff @(posedge CLK) begin
        if (RST) begin
          q_r  <= {BPW{1'b0}};
          qv_r <= 1'b0;
        end else begin
          if (pipe_v_r) begin
            q_r <= pipe_d_r;
          end else begin
            q_r <= q_r;
          end
          qv_r <= pipe_v_r;
        end
      end
    end else begin : g_noreg
      // Single read stage: Q updates only when a read is accepted.
      always_ff @(posedge CLK) begin
        if (RST) begin
          q_r  <= {BPW{1'b0}};
          qv_r <= 1'b0;
        end else begin
          if (rd_req_s) begin
            q_r <= rd_data_s;
          end else begin
            q_r <= q_r;
          end
          qv_r <= rd_req_s;
        end
      end
    end
  endgenerate

  assign Q    = q_r;
  assign QV   = qv_r;
  assign BUSY = busy_r;

endmodule

// File: tb/tb_sram_sp_bw.sv
// Directed self-checking bench for sram_sp_bw. Two instances share all
// inputs: dut0 has no output register, dut1 has the extra output stage.
module tb_sram_sp_bw;

  localparam logic [31:0] IV = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        wen;
  logic [3:0]  bwen;
  logic [7:0]  a;
  logic [31:0] d;
  logic [31:0] q0;
  logic        qv0;
  logic        busy0;
  logic [31:0] q1;
  logic        qv1;
  logic        busy1;

  int compared;
  int mismatched;

  sram_sp_bw #(.BPW(32), .WORD(256), .OREG(0), .INIT_VAL(IV)) dut0 (
    .CLK(clk), .RST(rst), .CEN(cen), .WEN(wen), .BWEN(bwen), .A(a), .D(d),
    .Q(q0), .QV(qv0), .BUSY(busy0)
  );

  sram_sp_bw #(.BPW(32), .WORD(256), .OREG(1), .INIT_VAL(IV)) dut1 (
    .CLK(clk), .RST(rst), .CEN(cen), .WEN(wen), .BWEN(bwen), .A(a), .D(d),
    .Q(q1), .QV(qv1), .BUSY(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic w, input logic [3:0] be,
                       input logic [7:0] ad, input logic [31:0] dd);
    cen  = c;
    wen  = w;
    bwen = be;
    a    = ad;
    d    = dd;
    cycle();
  endtask

  // Runs idle (optionally poking requests) until BUSY drops; n counts the
  // sampled cycles with BUSY high, qv_seen counts QV pulses seen meanwhile.
  task automatic run_sweep(input bit poke, output int n, output int qv_seen);
    n = 0;
    qv_seen = 0;
    while (busy0 === 1'b1 && n < 1000) begin
      if (qv0 === 1'b1 || qv1 === 1'b1) qv_seen++;
      if (poke && n == 50) drive(1'b0, 1'b0, 4'b0000, 8'd10, 32'hDEADBEEF);
      else if (poke && n == 60) drive(1'b0, 1'b1, 4'b0000, 8'd10, 32'h0);
      else drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    int qvs;
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd128; addrs[2] = 8'd255;
    rst = 1'b1;
    cycle();
    compared++;
    if (q0 !== 32'h0 || qv0 !== 1'b0 || busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state0: got Q=%h QV=%b BUSY=%b expected Q=0 QV=0 BUSY=1", q0, qv0, busy0);
    end
    compared++;
    if (q1 !== 32'h0 || qv1 !== 1'b0 || busy1 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_state1: got Q=%h QV=%b BUSY=%b expected Q=0 QV=0 BUSY=1", q1, qv1, busy1);
    end
    rst = 1'b0;
    run_sweep(1'b0, n, qvs);
    compared++;
    if (n !== 256) begin
      mismatched++;
      $display("FAIL sweep_len: got %0d cycles expected 256", n);
    end
    compared++;
    if (busy1 !== 1'b0) begin
      mismatched++;
      $display("FAIL sweep_busy1: got BUSY=%b expected 0", busy1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'b0000, addrs[i], 32'h0);
      compared++;
      if (q0 !== IV || qv0 !== 1'b1) begin
        mismatched++;
        $display("FAIL init_read[%0d]: got Q=%h QV=%b expected Q=%h QV=1", addrs[i], q0, qv0, IV);
      end
    end
    drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
  endtask

  task automatic test_byte_mask();
    drive(1'b0, 1'b0, 4'b0000, 8'd5, 32'h11223344);
    drive(1'b0, 1'b0, 4'b1010, 8'd5, 32'hFFFFFFFF);
    compared++;
    if (qv0 !== 1'b0) begin
      mismatched++;
      $display("FAIL write_no_qv: got QV=%b expected 0", qv0);
    end
    drive(1'b0, 1'b1, 4'b1111, 8'd5, 32'h0);
    compared++;
    if (q0 !== 32'h11FF33FF || qv0 !== 1'b1) begin
      mismatched++;
      $display("FAIL byte_mask: got Q=%h QV=%b expected Q=11ff33ff QV=1", q0, qv0);
    end
    drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
  endtask

  task automatic test_wr_rd();
    drive(1'b0, 1'b0, 4'b0000, 8'd20, 32'hCAFE0020);
    drive(1'b0, 1'b1, 4'b0000, 8'd20, 32'h0);
    compared++;
    if (q0 !== 32'hCAFE0020 || qv0 !== 1'b1) begin
      mismatched++;
      $display("FAIL write_then_read: got Q=%h QV=%b expected Q=cafe0020 QV=1", q0, qv0);
    end
    drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
  endtask

  task automatic test_latency();
    logic [31:0] v [3];
    logic        e0v;
    logic        e1v;
    v[0] = 32'h11110001; v[1] = 32'h22220002; v[2] = 32'h33330003;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'b0000, 8'(i + 1), v[i]);
    drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
    drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b0, 1'b1, 4'b1111, 8'(i + 1), 32'h0);
      else drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
      e0v = (i < 3);
      e1v = (i >= 1 && i <= 3);
      compared++;
      if (qv0 !== e0v || q0 !== v[(i < 3) ? i : 2]) begin
        mismatched++;
        $display("FAIL lat_oreg0[%0d]: got Q=%h QV=%b expected Q=%h QV=%b", i, q0, qv0, v[(i < 3) ? i : 2], e0v);
      end
      compared++;
      if (qv1 !== e1v || (i >= 1 && q1 !== v[(i <= 3) ? i - 1 : 2])) begin
        mismatched++;
        $display("FAIL lat_oreg1[%0d]: got Q=%h QV=%b expected QV=%b", i, q1, qv1, e1v);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b0, 4'b0000, 8'd7, 32'h00000007);
    drive(1'b0, 1'b1, 4'b0000, 8'd7, 32'h0);
    compared++;
    if (q0 !== 32'h7 || qv0 !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_read: got Q=%h QV=%b expected Q=00000007 QV=1", q0, qv0);
    end
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 1) drive(1'b0, 1'b0, 4'b0000, 8'(8 + i), 32'hFFFF0000);
      else drive(1'b1, 1'b0, 4'b0000, 8'd7, 32'h0);
      compared++;
      if (q0 !== 32'h7 || qv0 !== 1'b0) begin
        mismatched++;
        $display("FAIL hold[%0d]: got Q=%h QV=%b expected Q=00000007 QV=0", i, q0, qv0);
      end
    end
    compared++;
    if (q1 !== 32'h7 || qv1 !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_oreg1: got Q=%h QV=%b expected Q=00000007 QV=0", q1, qv1);
    end
  endtask

  task automatic test_busy_drop();
    int n;
    int qvs;
    // Read in flight in dut1 when reset hits: it must vanish.
    drive(1'b0, 1'b1, 4'b1111, 8'd5, 32'h0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
    compared++;
    if (qv1 !== 1'b0 || q1 !== 32'h0 || q0 !== 32'h0 || busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_inflight: got Q1=%h QV1=%b Q0=%h BUSY=%b expected 0 0 0 1", q1, qv1, q0, busy0);
    end
    rst = 1'b0;
    run_sweep(1'b1, n, qvs);
    compared++;
    if (n !== 256 || qvs !== 0) begin
      mismatched++;
      $display("FAIL busy_drop: got %0d cycles %0d QV pulses expected 256 cycles 0 pulses", n, qvs);
    end
    drive(1'b0, 1'b1, 4'b0000, 8'd10, 32'h0);
    compared++;
    if (q0 !== IV || qv0 !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_drop_read: got Q=%h QV=%b expected Q=%h QV=1", q0, qv0, IV);
    end
    drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
  endtask

  task automatic test_mid_reset();
    int n;
    int qvs;
    drive(1'b0, 1'b0, 4'b0000, 8'd200, 32'h12345678);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
    rst = 1'b1;
    cycle();
    compared++;
    if (busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_reset_busy: got BUSY=%b expected 1", busy0);
    end
    rst = 1'b0;
    run_sweep(1'b0, n, qvs);
    compared++;
    if (n !== 256) begin
      mismatched++;
      $display("FAIL mid_reset_len: got %0d cycles expected 256", n);
    end
    drive(1'b0, 1'b1, 4'b0000, 8'd200, 32'h0);
    compared++;
    if (q0 !== IV || qv0 !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_reset_read: got Q=%h QV=%b expected Q=%h QV=1", q0, qv0, IV);
    end
    drive(1'b1, 1'b1, 4'b1111, 8'd0, 32'h0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst  = 1'b1;
    cen  = 1'b1;
    wen  = 1'b1;
    bwen = 4'b1111;
    a    = 8'd0;
    d    = 32'h0;
    test_reset();
    test_byte_mask();
    test_wr_rd();
    test_latency();
    test_hold();
    test_busy_drop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
